// File: rtl/snn_aer_pkg.sv
// rtl/snn_aer_pkg.sv - shared AER link types and constants
package snn_aer_pkg;

   localparam int AER_ADDR_BITS = 10;

   // Address the encoder emits during its reset sequence; the link treats it as ordinary data
   localparam logic [AER_ADDR_BITS-1:0] AER_RST_ADDR = 10'h1FF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_UP = 2'd1,
      REQ_DN = 2'd2
   } aer_tx_state_t;

   // Width of a counter that must reach timeout-1; a disabled timeout still gets one bit
   function automatic int tmo_cnt_bits(input int timeout);
      return (timeout <= 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with asynchronous reset
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two back-to-back flops give the first stage a full cycle to resolve
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/aer_tx_ctrl.sv
// rtl/aer_tx_ctrl.sv - captures encoder AER indices and sends them over a 4-phase REQ/ACK link
module aer_tx_ctrl
   import snn_aer_pkg::*;
#(
   parameter int ADDR_BITS   = AER_ADDR_BITS,
   parameter int ACK_TIMEOUT = 1024,
   parameter int CNT_BITS    = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [ADDR_BITS-1:0] NEXT_INDEX,
   input  logic                 FOUND_NEXT_INDEX,
   output logic                 AERIN_CTRL_BUSY,
   output logic [ADDR_BITS-1:0] AERIN_ADDR,
   output logic                 AERIN_REQ,
   input  logic                 AERIN_ACK,
   input  logic                 CLR_ERR,
   output logic                 TIMEOUT_ERR,
   output logic                 DROP_ERR,
   output logic [CNT_BITS-1:0]  EVENT_CNT
);

   localparam int TMO_BITS = tmo_cnt_bits(ACK_TIMEOUT);
   localparam int TMO_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
   localparam bit TMO_EN   = (ACK_TIMEOUT > 0);

   aer_tx_state_t        state_q, state_d;
   logic                 ack_s;
   logic                 found_q;
   logic                 strobe;
   logic                 accept;
   logic                 timeout;
   logic                 tmo_set;
   logic                 drop_set;
   logic                 done;
   logic                 req_q, req_d;
   logic [TMO_BITS-1:0]  tmo_q, tmo_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [CNT_BITS-1:0]  cnt_q, cnt_d;
   logic                 tmo_err_q, tmo_err_d;
   logic                 drop_err_q, drop_err_d;

   sync_2ff #(
      .WIDTH (1)
   ) u_ack_sync (
      .CLK (CLK),
      .RST (RST),
      .d_i (AERIN_ACK),
      .q_o (ack_s)
   );

   // Only the first cycle of a 1-2 cycle strobe counts as a new index
   assign strobe   = FOUND_NEXT_INDEX & ~found_q;
   assign accept   = strobe & (state_q == IDLE);
   assign drop_set = strobe & (state_q != IDLE);
   assign timeout  = TMO_EN && (tmo_q == TMO_BITS'(TMO_LAST));

   // Handshake sequencing; ACK is only ever looked at after synchronisation
   always_comb begin
      state_d = state_q;
      tmo_set = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = REQ_UP;
         end
         REQ_UP: begin
            if (ack_s) begin
               state_d = REQ_DN;
            end else if (timeout) begin
               state_d = IDLE;
               tmo_set = 1'b1;
            end
         end
         REQ_DN: begin
            if (!ack_s) begin
               state_d = IDLE;
               done    = 1'b1;
            end else if (timeout) begin
               state_d = IDLE;
               tmo_set = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      req_d = (state_d == REQ_UP);
   end

   // Datapath next-state: address latch, counters and sticky flags (set beats clear)
   always_comb begin
      addr_d = accept ? NEXT_INDEX : addr_q;
      cnt_d  = done ? cnt_q + CNT_BITS'(1) : cnt_q;
      if (state_d != state_q) begin
         tmo_d = '0;
      end else if (state_q != IDLE) begin
         tmo_d = tmo_q + TMO_BITS'(1);
      end else begin
         tmo_d = '0;
      end
      tmo_err_d  = tmo_set  ? 1'b1 : (CLR_ERR ? 1'b0 : tmo_err_q);
      drop_err_d = drop_set ? 1'b1 : (CLR_ERR ? 1'b0 : drop_err_q);
   end

   // All state drops immediately on reset, abandoning any handshake in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         found_q    <= 1'b0;
         req_q      <= 1'b0;
         tmo_q      <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         tmo_err_q  <= 1'b0;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         found_q    <= FOUND_NEXT_INDEX;
         req_q      <= req_d;
         tmo_q      <= tmo_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         tmo_err_q  <= tmo_err_d;
         drop_err_q <= drop_err_d;
      end
   end

   // Busy covers the accept cycle combinationally so the encoder never issues into a full link
   assign AERIN_CTRL_BUSY = (state_q != IDLE) | accept;
   assign AERIN_ADDR      = addr_q;
   assign AERIN_REQ       = req_q;
   assign TIMEOUT_ERR     = tmo_err_q;
   assign DROP_ERR        = drop_err_q;
   assign EVENT_CNT       = cnt_q;

endmodule

// File: doc/aer_tx_ctrl.md
Name: aer_tx_ctrl

Overview:
Downstream neighbour of the rank-order (ROC) encoder. It captures each 10-bit AER index the encoder strobes out and transmits it to the SNN core over a 4-phase REQ/ACK handshake. It drives the busy flag the encoder waits on before it issues the next index. ACK crosses from the core's domain through a 2-flop synchroniser; an optional timeout and sticky error flags guard against a stalled core.

Parameters:
ADDR_BITS, 10, AER address width (matches the encoder output link)
ACK_TIMEOUT, 1024, maximum cycles spent waiting for each ACK edge; 0 disables the timeout
CNT_BITS, 16, width of the completed-event counter

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
NEXT_INDEX  in  ADDR_BITS  index from the encoder; valid while FOUND_NEXT_INDEX is high
FOUND_NEXT_INDEX  in  1  encoder strobe; high for 1-2 consecutive cycles per index
AERIN_CTRL_BUSY  out  1  to encoder; high while an index is being transmitted
AERIN_ADDR  out  ADDR_BITS  address to the core
AERIN_REQ  out  1  request to the core
AERIN_ACK  in  1  acknowledge from the core (asynchronous)
CLR_ERR  in  1  synchronous clear of the sticky error flags
TIMEOUT_ERR  out  1  sticky; an ACK edge was not seen within ACK_TIMEOUT cycles
DROP_ERR  out  1  sticky; a strobe arrived while the block was not in IDLE
EVENT_CNT  out  CNT_BITS  count of completed handshakes; wraps modulo 2^CNT_BITS

Behaviour:
- Reset values: all outputs 0; state IDLE; synchroniser flops 0; found_q 0.
- ack_s: AERIN_ACK passed through 2 flops. All FSM decisions use ack_s only.
- found_q: FOUND_NEXT_INDEX registered.
- Strobe rule: strobe = FOUND_NEXT_INDEX & ~found_q (rising edge). A 2-cycle strobe yields exactly one transfer.
- Accept: strobe while state==IDLE.
  - NEXT_INDEX is latched into AERIN_ADDR at the clock edge ending the accept cycle.
  - Next state is REQ_UP.
- Strobe while state!=IDLE: the index is discarded; DROP_ERR is set.
- AERIN_CTRL_BUSY = (state!=IDLE) | accept. This is combinational, so busy is high in the accept cycle and every cycle until IDLE returns.
- AERIN_ADDR is held stable from the cycle after accept until the next accept.
- FSM (registered state, REQ is a registered output):
  - IDLE: REQ=0. On accept -> REQ_UP.
  - REQ_UP: REQ=1. If ack_s==1 -> REQ_DN. If timeout -> IDLE and set TIMEOUT_ERR.
  - REQ_DN: REQ=0. If ack_s==0 -> IDLE and increment EVENT_CNT. If timeout -> IDLE and set TIMEOUT_ERR; EVENT_CNT is not incremented.
- REQ rises in the first cycle after accept. REQ falls in the cycle after ack_s is seen high.
- Minimum busy span, with the core acking immediately: accept cycle + 2 sync cycles + 1 + 2 sync cycles + 1, about 7 cycles.
- Timeout counter:
  - Clears on every state change.
  - Increments each cycle spent in REQ_UP or REQ_DN.
  - Timeout = (cnt == ACK_TIMEOUT-1) when ACK_TIMEOUT != 0.
  - Width is $clog2(ACK_TIMEOUT+1), minimum 1.
- After a timeout in REQ_UP, REQ is dropped. The next transfer proceeds normally; a stale ack_s=1 completes it early. That is acceptable because TIMEOUT_ERR already flags the corruption.
- CLR_ERR clears both flags. If a set event occurs in the same cycle as CLR_ERR, set wins.
- Reset mid-handshake: REQ drops immediately (asynchronous), state returns to IDLE, the counter clears, and the in-flight index is lost.

Decomposition:
- Shared package snn_aer_pkg:
  - typedef aer_tx_state_t {IDLE, REQ_UP, REQ_DN}
  - localparam AER_ADDR_BITS = 10
  - localparam AER_RST_ADDR = 10'h1FF (encoder reset-sequence address; this block treats it like any other address)
- One sub-module, sync_2ff: generic 2-flop synchroniser with async reset. It is reused for other core-domain inputs.

Test Plan:
- Single transfer: strobe 2 cycles with NEXT_INDEX=10'h02A; core acks 3 cycles after REQ and drops ACK 3 cycles after REQ falls -> AERIN_ADDR=0x02A, exactly one REQ pulse, BUSY high from the strobe cycle until IDLE, EVENT_CNT=1.
- Reset sequence: two back-to-back 1-cycle strobes of 0x1FF, each issued after BUSY falls, then index 0x005 -> three handshakes with addresses 0x1FF, 0x1FF, 0x005; EVENT_CNT=3; DROP_ERR=0.
- Drop: second rising strobe (0x010) while in REQ_UP -> DROP_ERR=1; AERIN_ADDR stays at the first index; only one handshake occurs. CLR_ERR pulse -> DROP_ERR=0.
- Timeout: ACK_TIMEOUT=8, ACK held 0 -> REQ high for exactly 8 cycles, then REQ=0, TIMEOUT_ERR=1, BUSY=0, EVENT_CNT unchanged.
- Async reset mid-REQ_UP -> REQ, BUSY, and EVENT_CNT go to 0 without waiting for a clock edge. A following strobe of 0x0FF completes normally.
- Counter wrap: CNT_BITS=4, 17 transfers -> EVENT_CNT=1.
